// File: rtl/capp_pkg.sv
// Shared types and index helpers for the CAPP associative search unit.
package capp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StResolve
  } capp_state_e;

  function automatic int unsigned capp_idxw(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

  // Match-line pair for comparand bit i: positive line drives a stored 1, negative a stored 0.
  function automatic int unsigned ml_pos(input int unsigned bit_idx);
    return 2 * bit_idx;
  endfunction

  function automatic int unsigned ml_neg(input int unsigned bit_idx);
    return 2 * bit_idx + 1;
  endfunction

endpackage

// File: rtl/capp_priority_enc.sv
// Lowest-set-bit priority encoder over the tag vector.
module capp_priority_enc
  import capp_pkg::*;
#(
  parameter int unsigned WORDS = 16,
  parameter int unsigned IDXW  = capp_idxw(WORDS)
) (
  input  logic [WORDS-1:0] req_i,
  output logic [IDXW-1:0]  idx_o,
  output logic             nonzero_o
);

  // Scan downwards so the lowest set bit is the last assignment and wins.
  always_comb begin
    idx_o = '0;
    for (int i = int'(WORDS) - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IDXW'(i);
    end
  end

  assign nonzero_o = |req_i;

endmodule

// File: rtl/capp_search_unit.sv
// Associative search engine: masked parallel compare sets tags, responders drained lowest-first.
module capp_search_unit
  import capp_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned WORDS = 16,
  localparam int unsigned IDXW = capp_idxw(WORDS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [IDXW-1:0]    wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [WIDTH-1:0]   cmd_comparand,
  input  logic [WIDTH-1:0]   cmd_mask,
  input  logic               cmd_accumulate,
  input  logic               rsp_flush,
  output logic [2*WIDTH-1:0] match_lines,
  output logic [WORDS-1:0]   tags,
  output logic               any_match,
  output logic               search_done,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDXW-1:0]    rsp_index,
  output logic [WIDTH-1:0]   rsp_data
);

  capp_state_e        state_q, state_d;
  logic [WIDTH-1:0]   mem_q [WORDS];
  logic [WIDTH-1:0]   mem_d [WORDS];
  logic [WIDTH-1:0]   comparand_q, comparand_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic               acc_q, acc_d;
  logic [2*WIDTH-1:0] match_lines_q, match_lines_d;
  logic [WORDS-1:0]   tags_q, tags_d;
  logic               any_match_q, any_match_d;
  logic               search_done_q, search_done_d;

  logic [WORDS-1:0]   search_tags;
  logic [WORDS-1:0]   rsp_onehot;
  logic [WORDS-1:0]   tags_popped;
  logic [IDXW-1:0]    rsp_idx;
  logic               rsp_nz;
  logic               srch_idx_unused_nz;
  logic [IDXW-1:0]    srch_idx_unused;

  capp_priority_enc #(
    .WORDS (WORDS),
    .IDXW  (IDXW)
  ) u_rsp_enc (
    .req_i     (tags_q),
    .idx_o     (rsp_idx),
    .nonzero_o (rsp_nz)
  );

  capp_priority_enc #(
    .WORDS (WORDS),
    .IDXW  (IDXW)
  ) u_srch_enc (
    .req_i     (search_tags),
    .idx_o     (srch_idx_unused),
    .nonzero_o (srch_idx_unused_nz)
  );

  // Parallel compare against registered contents, so a coincident write is not seen.
  always_comb begin
    search_tags = '0;
    for (int k = 0; k < int'(WORDS); k++) begin
      search_tags[k] = (acc_q ? tags_q[k] : 1'b1) &
                       ~|((mem_q[k] ^ comparand_q) & mask_q);
    end
  end

  always_comb begin
    for (int k = 0; k < int'(WORDS); k++) begin
      mem_d[k] = (wr_en && (wr_addr == IDXW'(k))) ? wr_data : mem_q[k];
    end
  end

  always_comb begin
    rsp_onehot = '0;
    for (int k = 0; k < int'(WORDS); k++) begin
      rsp_onehot[k] = (rsp_idx == IDXW'(k));
    end
    tags_popped = tags_q & ~rsp_onehot;
  end

  always_comb begin
    state_d       = state_q;
    comparand_d   = comparand_q;
    mask_d        = mask_q;
    acc_d         = acc_q;
    match_lines_d = match_lines_q;
    tags_d        = tags_q;
    any_match_d   = any_match_q;
    search_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          comparand_d = cmd_comparand;
          mask_d      = cmd_mask;
          acc_d       = cmd_accumulate;
          for (int i = 0; i < int'(WIDTH); i++) begin
            match_lines_d[ml_pos(i)] = cmd_comparand[i] & cmd_mask[i];
            match_lines_d[ml_neg(i)] = ~cmd_comparand[i] & cmd_mask[i];
          end
          state_d = StSearch;
        end
      end
      StSearch: begin
        tags_d        = search_tags;
        search_done_d = 1'b1;
        any_match_d   = srch_idx_unused_nz;
        state_d       = srch_idx_unused_nz ? StResolve : StIdle;
      end
      StResolve: begin
        if (rsp_flush) begin
          tags_d  = '0;
          state_d = StIdle;
        end else if (rsp_ready) begin
          tags_d = tags_popped;
          if (~|tags_popped) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      comparand_q   <= '0;
      mask_q        <= '0;
      acc_q         <= 1'b0;
      match_lines_q <= '0;
      tags_q        <= '0;
      any_match_q   <= 1'b0;
      search_done_q <= 1'b0;
      for (int k = 0; k < int'(WORDS); k++) mem_q[k] <= '0;
    end else begin
      state_q       <= state_d;
      comparand_q   <= comparand_d;
      mask_q        <= mask_d;
      acc_q         <= acc_d;
      match_lines_q <= match_lines_d;
      tags_q        <= tags_d;
      any_match_q   <= any_match_d;
      search_done_q <= search_done_d;
      for (int k = 0; k < int'(WORDS); k++) mem_q[k] <= mem_d[k];
    end
  end

  assign cmd_ready   = (state_q == StIdle);
  assign rsp_valid   = (state_q == StResolve) & rsp_nz;
  assign rsp_index   = rsp_idx;
  assign rsp_data    = mem_q[rsp_idx];
  assign match_lines = match_lines_q;
  assign tags        = tags_q;
  assign any_match   = any_match_q;
  assign search_done = search_done_q;

endmodule

// File: tb/tb_capp_search_unit.sv
// Self-checking bench for capp_search_unit (WIDTH=8, WORDS=4) with a behavioural tag model.
module tb_capp_search_unit;

  localparam int unsigned W = 8;
  localparam int unsigned N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wr_en = 1'b0;
  logic [1:0]     wr_addr = '0;
  logic [W-1:0]   wr_data = '0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [W-1:0]   cmd_comparand = '0;
  logic [W-1:0]   cmd_mask = '0;
  logic           cmd_accumulate = 1'b0;
  logic           rsp_flush = 1'b0;
  logic [2*W-1:0] match_lines;
  logic [N-1:0]   tags;
  logic           any_match;
  logic           search_done;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [1:0]     rsp_index;
  logic [W-1:0]   rsp_data;

  capp_search_unit #(
    .WIDTH (W),
    .WORDS (N)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_comparand  (cmd_comparand),
    .cmd_mask       (cmd_mask),
    .cmd_accumulate (cmd_accumulate),
    .rsp_flush      (rsp_flush),
    .match_lines    (match_lines),
    .tags           (tags),
    .any_match      (any_match),
    .search_done    (search_done),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_index      (rsp_index),
    .rsp_data       (rsp_data)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  logic [W-1:0] m_mem [N];
  logic [N-1:0] m_tags;
  logic         m_any;

  typedef struct {
    logic [W-1:0] comp;
    logic [W-1:0] mask;
    logic         acc;
    logic [N-1:0] exp_tags;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lowest(input logic [N-1:0] t);
    for (int i = 0; i < int'(N); i++) if (t[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(N); i++) m_mem[i] = '0;
    m_tags = '0;
    m_any  = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [W-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    m_mem[a] = d;
  endtask

  task automatic do_search(input logic [W-1:0] comp, input logic [W-1:0] mask, input logic acc,
                           input logic col_wr, input logic [1:0] col_a, input logic [W-1:0] col_d);
    logic [2*W-1:0] exp_ml;
    logic [N-1:0]   newt;
    check("cmd_ready_idle", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1; cmd_comparand = comp; cmd_mask = mask; cmd_accumulate = acc;
    tick();
    // Scramble command inputs: the unit must use the latched copies.
    cmd_valid = 1'b0; cmd_comparand = 8'($urandom); cmd_mask = 8'($urandom);
    cmd_accumulate = 1'($urandom);
    for (int i = 0; i < int'(W); i++) begin
      exp_ml[2*i]   = comp[i] & mask[i];
      exp_ml[2*i+1] = ~comp[i] & mask[i];
    end
    check("match_lines", 64'(match_lines), 64'(exp_ml));
    check("cmd_ready_search", 64'(cmd_ready), 64'(0));
    check("rsp_valid_search", 64'(rsp_valid), 64'(0));
    for (int k = 0; k < int'(N); k++) begin
      newt[k] = (acc ? m_tags[k] : 1'b1) & (((m_mem[k] ^ comp) & mask) == '0);
    end
    if (col_wr) begin
      wr_en = 1'b1; wr_addr = col_a; wr_data = col_d;
    end
    tick();
    wr_en = 1'b0;
    if (col_wr) m_mem[col_a] = col_d;
    m_tags = newt;
    m_any  = (newt != '0);
    check("tags_after_search", 64'(tags), 64'(m_tags));
    check("search_done_pulse", 64'(search_done), 64'(1));
    check("any_match", 64'(any_match), 64'(m_any));
    check("rsp_valid_after_search", 64'(rsp_valid), 64'(m_any));
    check("cmd_ready_after_search", 64'(cmd_ready), 64'(!m_any));
    tick();
    check("search_done_low", 64'(search_done), 64'(0));
    check("any_match_hold", 64'(any_match), 64'(m_any));
    check("tags_hold", 64'(tags), 64'(m_tags));
  endtask

  task automatic drain(input int stall_pct, input int flush_after, input int wr_pct);
    int accepts = 0;
    int guard = 0;
    int idx;
    bit rdy, fl, wr;
    logic [1:0] wa;
    logic [W-1:0] wd;
    while (m_tags != '0 && guard < 200) begin
      guard++;
      idx = lowest(m_tags);
      check("rsp_valid", 64'(rsp_valid), 64'(1));
      check("rsp_index", 64'(rsp_index), 64'(idx));
      check("rsp_data", 64'(rsp_data), 64'(m_mem[idx]));
      check("tags_resolve", 64'(tags), 64'(m_tags));
      fl  = (accepts == flush_after);
      rdy = fl ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
      wr  = ($urandom_range(0, 99) < wr_pct);
      wa  = 2'($urandom);
      wd  = 8'($urandom);
      rsp_flush = fl; rsp_ready = rdy;
      wr_en = wr; wr_addr = wa; wr_data = wd;
      tick();
      rsp_flush = 1'b0; rsp_ready = 1'b0; wr_en = 1'b0;
      if (fl) m_tags = '0;
      else if (rdy) begin
        m_tags[idx] = 1'b0;
        accepts++;
      end
      if (wr) m_mem[wa] = wd;
    end
    if (guard >= 200) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_bound: responders still pending after %0d cycles", guard);
    end
    check("rsp_valid_drained", 64'(rsp_valid), 64'(0));
    check("cmd_ready_drained", 64'(cmd_ready), 64'(1));
    check("tags_drained", 64'(tags), 64'(0));
    check("any_match_sticky", 64'(any_match), 64'(m_any));
  endtask

  task automatic load_base();
    do_write(2'd0, 8'hA5);
    do_write(2'd1, 8'h3C);
    do_write(2'd2, 8'hA0);
    do_write(2'd3, 8'hFF);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{comp: 8'hA0, mask: 8'hF0, acc: 1'b0, exp_tags: 4'b0101};
    vecs[1] = '{comp: 8'h00, mask: 8'hFF, acc: 1'b0, exp_tags: 4'b0000};
    vecs[2] = '{comp: 8'hA5, mask: 8'hFF, acc: 1'b0, exp_tags: 4'b0001};
    vecs[3] = '{comp: 8'h00, mask: 8'h00, acc: 1'b0, exp_tags: 4'b1111};
    vecs[4] = '{comp: 8'h0C, mask: 8'h0F, acc: 1'b0, exp_tags: 4'b0010};
    vecs[5] = '{comp: 8'h05, mask: 8'h0F, acc: 1'b1, exp_tags: 4'b0000};
    vecs[6] = '{comp: 8'h3C, mask: 8'h3C, acc: 1'b0, exp_tags: 4'b1010};
    model_reset();

    // Reset held with random inputs
    tick();
    for (int c = 0; c < 3; c++) begin
      wr_en = 1'($urandom); wr_addr = 2'($urandom); wr_data = 8'($urandom);
      cmd_valid = 1'($urandom); cmd_comparand = 8'($urandom); cmd_mask = 8'($urandom);
      rsp_ready = 1'($urandom); rsp_flush = 1'($urandom);
      tick();
      check("rst_match_lines", 64'(match_lines), 64'(0));
      check("rst_tags", 64'(tags), 64'(0));
      check("rst_any_match", 64'(any_match), 64'(0));
      check("rst_search_done", 64'(search_done), 64'(0));
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
      check("rst_rsp_data", 64'(rsp_data), 64'(0));
    end
    wr_en = 0; cmd_valid = 0; rsp_ready = 0; rsp_flush = 0;
    rst_n = 1'b1;
    tick();
    do_search(8'h00, 8'hFF, 1'b0, 1'b0, 2'd0, 8'h00);
    check("rst_word_all_hit", 64'(tags), 64'(4'b1111));
    drain(0, -1, 0);

    // Table-driven searches on the base contents
    load_base();
    for (int v = 0; v < 7; v++) begin
      do_search(vecs[v].comp, vecs[v].mask, vecs[v].acc, 1'b0, 2'd0, 8'h00);
      check("vec_tags", 64'(tags), 64'(vecs[v].exp_tags));
      drain(40, -1, 0);
    end

    // Accept one then flush; flush immediately; accumulate after flush
    do_search(8'hA0, 8'hF0, 1'b0, 1'b0, 2'd0, 8'h00);
    drain(0, 1, 0);
    do_search(8'hA0, 8'hF0, 1'b0, 1'b0, 2'd0, 8'h00);
    drain(0, 0, 0);
    do_search(8'h05, 8'h0F, 1'b1, 1'b0, 2'd0, 8'h00);
    check("acc_after_flush", 64'(tags), 64'(0));
    do_write(2'd3, 8'h85);
    do_search(8'h05, 8'h0F, 1'b0, 1'b0, 2'd0, 8'h00);
    check("fresh_low_nibble", 64'(tags), 64'(4'b1001));
    drain(0, 0, 0);
    do_search(8'h80, 8'h80, 1'b1, 1'b0, 2'd0, 8'h00);
    check("acc_idle_no_match", 64'(any_match), 64'(0));

    // Backpressure with mask zero, write under the current index
    do_search(8'h5A, 8'h00, 1'b0, 1'b0, 2'd0, 8'h00);
    check("mask0_all", 64'(tags), 64'(4'b1111));
    for (int c = 0; c < 5; c++) begin
      check("stall_index", 64'(rsp_index), 64'(0));
      check("stall_data", 64'(rsp_data), 64'(m_mem[0]));
      tick();
    end
    do_write(2'd0, 8'h11);
    check("rsp_data_after_write", 64'(rsp_data), 64'(8'h11));
    drain(0, -1, 0);

    // Write coinciding with the SEARCH edge sees old data
    load_base();
    do_search(8'hA0, 8'hF0, 1'b0, 1'b1, 2'd2, 8'h00);
    check("collision_tag2", 64'(tags), 64'(4'b0101));
    drain(0, -1, 0);

    // Asynchronous reset in RESOLVE
    load_base();
    do_search(8'hA0, 8'hF0, 1'b0, 1'b0, 2'd0, 8'h00);
    rst_n = 1'b0;
    #1;
    check("midrst_tags", 64'(tags), 64'(0));
    check("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("midrst_any_match", 64'(any_match), 64'(0));
    check("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    do_search(8'h00, 8'hFF, 1'b0, 1'b0, 2'd0, 8'h00);
    check("midrst_mem_cleared", 64'(tags), 64'(4'b1111));
    drain(0, 0, 0);

    // Randomised traffic against the model
    for (int it = 0; it < 60; it++) begin
      logic [W-1:0] comp, mask;
      if ($urandom_range(0, 1) == 1) do_write(2'($urandom), 8'($urandom));
      comp = ($urandom_range(0, 2) == 0) ? 8'($urandom) : (m_mem[2'($urandom)] ^ 8'($urandom_range(0, 3)));
      mask = 8'($urandom) & 8'($urandom) & 8'($urandom);
      do_search(comp, mask, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
                2'($urandom), 8'($urandom));
      drain(50, ($urandom_range(0, 4) == 0) ? $urandom_range(0, 2) : -1, 25);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
